// File: rtl/cam_match_encoder.sv
// -----------------------------------------------------------------------------
// cam_match_encoder
//
// Purpose:
//   Captures one row-match vector from the CAM cell array per search. It then
//   reports every matching row address in ascending order, one address per
//   handshake beat. If no row matched, it reports a single miss beat instead.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   match_i       in   [ENTRIES]     row match vector (bit r = row r matched)
//   valid_i       in                 match_i valid this cycle
//   ready_o       out                encoder idle, can capture a vector
//   hit_valid_o   out                result beat valid
//   hit_ready_i   in                 consumer accepts the beat
//   hit_addr_o    out  [ADDR_W]      matching row address (0 on a miss beat)
//   miss_o        out                beat reports no match
//   hit_last_o    out                final beat of this search
//   match_count_o out  [clog2(E+1)]  popcount of the captured vector
//                                    (only when CAM_MATCH_COUNT_EN is defined)
//
// Configuration macro:
//   CAM_MATCH_COUNT_EN - adds match_count_o and its popcount logic.
// -----------------------------------------------------------------------------
module cam_match_encoder #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ENTRIES-1:0] match_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              hit_valid_o,
  input  logic              hit_ready_i,
  output logic [ADDR_W-1:0] hit_addr_o,
  output logic              miss_o,
  output logic              hit_last_o
`ifdef CAM_MATCH_COUNT_EN
  ,
  output logic [$clog2(ENTRIES+1)-1:0] match_count_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIT  = 2'd1,
    S_MISS = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [ENTRIES-1:0]   r_pending;
  logic [ENTRIES-1:0]   w_pending_next;

  // Lowest-set-bit encoder and helpers, all driven only by r_pending.
  logic [ADDR_W-1:0]    w_low_addr;
  logic [ENTRIES-1:0]   w_pending_cleared;
  logic                 w_one_left;

  // Subtracting one flips the lowest set bit and every zero below it. ANDing
  // with the original value therefore removes exactly that lowest set bit.
  assign w_pending_cleared = r_pending & (r_pending - {{(ENTRIES-1){1'b0}}, 1'b1});

  // Exactly one bit is set when removing the lowest one leaves nothing.
  assign w_one_left = (r_pending != '0) && (w_pending_cleared == '0);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    w_low_addr = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_low_addr = ADDR_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and pending-vector registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode. The outputs depend only on r_state and
  // r_pending. Inputs steer only the next-state terms, so match_i and
  // hit_ready_i have no path to any output.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    ready_o        = 1'b0;
    hit_valid_o    = 1'b0;
    miss_o         = 1'b0;
    hit_last_o     = 1'b0;
    hit_addr_o     = '0;

    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          w_pending_next = match_i;
          w_state_next   = (match_i != '0) ? S_HIT : S_MISS;
        end
      end

      S_HIT: begin
        hit_valid_o = 1'b1;
        hit_addr_o  = w_low_addr;
        hit_last_o  = w_one_left;
        if (hit_ready_i) begin
          w_pending_next = w_pending_cleared;
          if (w_one_left) begin
            w_state_next = S_IDLE;
          end
        end
      end

      S_MISS: begin
        hit_valid_o = 1'b1;
        miss_o      = 1'b1;
        hit_last_o  = 1'b1;
        if (hit_ready_i) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next   = S_IDLE;
        w_pending_next = '0;
      end
    endcase
  end

`ifdef CAM_MATCH_COUNT_EN
  // ---------------------------------------------------------------------------
  // Optional hit count. It is loaded at capture and held across all beats.
  // It drops back to zero whenever the encoder is about to return to idle.
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(ENTRIES + 1);

  logic [CNT_W-1:0] w_popcount;
  logic [CNT_W-1:0] r_count;

  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_popcount = w_popcount + {{(CNT_W-1){1'b0}}, match_i[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_state == S_IDLE && valid_i) begin
      r_count <= w_popcount;
    end else if (w_state_next == S_IDLE) begin
      r_count <= '0;
    end
  end

  assign match_count_o = r_count;
`endif

endmodule

// File: tb/tb_cam_match_encoder.sv
module tb_cam_match_encoder;

  localparam int ENTRIES = 8;
  localparam int ADDR_W  = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              miss;
    logic              last;
  } beat_t;

  logic               clk;
  logic               reset;
  logic [ENTRIES-1:0] match_i;
  logic               valid_i;
  logic               ready_o;
  logic               hit_valid_o;
  logic               hit_ready_i;
  logic [ADDR_W-1:0]  hit_addr_o;
  logic               miss_o;
  logic               hit_last_o;
`ifdef CAM_MATCH_COUNT_EN
  logic [3:0]         match_count_o;
`endif

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];
  int    exp_cnt = 0;

  cam_match_encoder #(.ENTRIES(ENTRIES)) dut (
    .clk         (clk),
    .reset       (reset),
    .match_i     (match_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .hit_valid_o (hit_valid_o),
    .hit_ready_i (hit_ready_i),
    .hit_addr_o  (hit_addr_o),
    .miss_o      (miss_o),
    .hit_last_o  (hit_last_o)
`ifdef CAM_MATCH_COUNT_EN
    ,
    .match_count_o (match_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_count(input string tag, input int exp);
`ifdef CAM_MATCH_COUNT_EN
    check(tag, {28'd0, match_count_o}, exp);
`endif
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Push the expected beats for one search: addresses ascending, last on the
  // highest set bit, or a single miss beat when the vector is empty.
  task automatic push_expected(input logic [ENTRIES-1:0] vec);
    beat_t b;
    logic [ENTRIES-1:0] above;
    exp_cnt = 0;
    if (vec == '0) begin
      b.addr = '0; b.miss = 1'b1; b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (vec[i]) begin
          above  = vec >> (i + 1);
          b.addr = ADDR_W'(i);
          b.miss = 1'b0;
          b.last = (above == '0);
          exp_q.push_back(b);
          exp_cnt++;
        end
      end
    end
  endtask

  // One complete search: capture, optional stall on the first beat, then
  // drain all beats with hit_ready_i held high. When poke is set, valid_i is
  // pulsed with an all-ones vector while beats are in flight.
  task automatic run_search(input string name, input logic [ENTRIES-1:0] vec,
                            input int stall, input bit poke);
    beat_t e;
    int budget;
    check({name, "_ready_before"}, ready_o, 1);
    match_i = vec;
    valid_i = 1'b1;
    push_expected(vec);
    step();
    valid_i = 1'b0;
    match_i = ENTRIES'($urandom);
    for (int s = 0; s < stall; s++) begin
      hit_ready_i = 1'b0;
      e = exp_q[0];
      check({name, "_stall_valid"}, hit_valid_o, 1);
      check({name, "_stall_addr"}, hit_addr_o, e.addr);
      check({name, "_stall_last"}, hit_last_o, e.last);
      check_count({name, "_stall_count"}, exp_cnt);
      step();
    end
    hit_ready_i = 1'b1;
    if (poke) begin
      valid_i = 1'b1;
      match_i = '1;
    end
    budget = 0;
    while (exp_q.size() > 0 && budget < 4 * ENTRIES) begin
      e = exp_q.pop_front();
      check({name, "_beat_valid"}, hit_valid_o, 1);
      check({name, "_beat_ready_o"}, ready_o, 0);
      check({name, "_beat_addr"}, hit_addr_o, e.addr);
      check({name, "_beat_miss"}, miss_o, e.miss);
      check({name, "_beat_last"}, hit_last_o, e.last);
      check_count({name, "_beat_count"}, exp_cnt);
      $display("beat %s addr=%0d miss=%0b last=%0b", name, hit_addr_o, miss_o, hit_last_o);
      step();
      budget++;
    end
    valid_i     = 1'b0;
    hit_ready_i = 1'b0;
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_ready_after"}, ready_o, 1);
    check({name, "_idle_valid"}, hit_valid_o, 0);
    check_count({name, "_idle_count"}, 0);
  endtask

  initial begin
    beat_t e;
    reset       = 1'b1;
    match_i     = '0;
    valid_i     = 1'b0;
    hit_ready_i = 1'b0;

    // Reset then idle.
    step();
    step();
    reset = 1'b0;
    check("rst_ready", ready_o, 1);
    check("rst_hit_valid", hit_valid_o, 0);
    check("rst_addr", hit_addr_o, 0);
    check("rst_miss", miss_o, 0);
    check("rst_last", hit_last_o, 0);
    check_count("rst_count", 0);

    // Single hit, multi-hit with back-pressure, miss with stray valid_i,
    // all ones, and a couple of extra patterns.
    run_search("single", 8'b0010_0000, 0, 1'b0);
    run_search("multi", 8'b1000_1001, 3, 1'b0);
    run_search("miss", 8'b0000_0000, 0, 1'b1);
    run_search("allones", 8'hFF, 0, 1'b0);
    run_search("top_bit", 8'b1000_0000, 1, 1'b0);
    run_search("mixed", 8'b0110_0110, 2, 1'b0);

    // Reset mid-search: accept beat 4, then reset while beat 6 is showing.
    match_i = 8'b0101_0000;
    valid_i = 1'b1;
    push_expected(8'b0101_0000);
    step();
    valid_i     = 1'b0;
    hit_ready_i = 1'b1;
    e = exp_q.pop_front();
    check("rstmid_beat0_addr", hit_addr_o, e.addr);
    check("rstmid_beat0_last", hit_last_o, e.last);
    step();
    hit_ready_i = 1'b0;
    e = exp_q[0];
    check("rstmid_beat1_addr", hit_addr_o, e.addr);
    check("rstmid_beat1_valid", hit_valid_o, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    check("rstmid_hit_valid", hit_valid_o, 0);
    check("rstmid_ready", ready_o, 1);
    check("rstmid_addr", hit_addr_o, 0);
    check_count("rstmid_count", 0);
    hit_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("rstmid_no_emit", hit_valid_o, 0);
    end
    hit_ready_i = 1'b0;

    // Normal operation resumes after the reset.
    run_search("post_rst", 8'b0000_0011, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
